// File: rtl/dds_sample_monitor.sv
// rtl/dds_sample_monitor.sv - gated frequency/amplitude monitor for the DDS->DAC sample stream
// Optional period measurement is built when MON_PERIOD_EN is defined.
module dds_sample_monitor #(
  parameter int DATA_W      = 14,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HYST        = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [DATA_W-1:0] Sample,
  input  logic              Sample_Valid,
  output logic [31:0]       Freq_Count,
  output logic [DATA_W-1:0] Max_Val,
  output logic [DATA_W-1:0] Min_Val,
  output logic [DATA_W-1:0] Vpp,
  output logic [31:0]       Period_Cnt,
  output logic              Meas_Valid,
  output logic              Busy
);

  localparam int              MID       = 2 ** (DATA_W - 1);
  localparam logic [DATA_W-1:0] HI_THR  = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO_THR  = DATA_W'(MID - HYST);
  localparam logic [31:0]     GATE_LAST = 32'(GATE_CYCLES - 1);

  typedef enum logic {LOW, HIGH} level_t;

  level_t            state, state_nxt;
  logic              rise;
  logic [31:0]       gate_cnt;
  logic [31:0]       acc_count, cnt_nxt;
  logic [DATA_W-1:0] acc_max, acc_min, max_nxt, min_nxt;
  logic              seen, seen_nxt;

  // Hysteresis comparator; the level persists across windows and enable gaps.
  always_ff @(posedge Clk) begin
    if (Reset) state <= LOW;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    if (Sample_Valid) begin
      case (state)
        LOW: if (Sample >= HI_THR) begin
          state_nxt = HIGH;
          rise      = 1'b1;
        end
        HIGH: if (Sample <= LO_THR) state_nxt = LOW;
        default: state_nxt = LOW;
      endcase
    end
  end

  // Accumulator values including this cycle's sample, so the closing cycle is counted.
  always_comb begin
    cnt_nxt  = (rise && acc_count != 32'hFFFF_FFFF) ? acc_count + 32'd1 : acc_count;
    seen_nxt = seen | Sample_Valid;
    max_nxt  = acc_max;
    min_nxt  = acc_min;
    if (Sample_Valid && (!seen || Sample > acc_max)) max_nxt = Sample;
    if (Sample_Valid && (!seen || Sample < acc_min)) min_nxt = Sample;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      gate_cnt   <= '0;
      acc_count  <= '0;
      acc_max    <= '0;
      acc_min    <= '1;
      seen       <= 1'b0;
      Freq_Count <= '0;
      Max_Val    <= '0;
      Min_Val    <= '0;
      Vpp        <= '0;
      Meas_Valid <= 1'b0;
    end else begin
      Meas_Valid <= 1'b0;
      if (!Enable || gate_cnt == GATE_LAST) begin
        gate_cnt  <= '0;
        acc_count <= '0;
        acc_max   <= '0;
        acc_min   <= '1;
        seen      <= 1'b0;
        if (Enable) begin
          Meas_Valid <= 1'b1;
          Freq_Count <= cnt_nxt;
          Max_Val    <= seen_nxt ? max_nxt : '0;
          Min_Val    <= seen_nxt ? min_nxt : '0;
          Vpp        <= seen_nxt ? max_nxt - min_nxt : '0;
        end
      end else begin
        gate_cnt  <= gate_cnt + 32'd1;
        acc_count <= cnt_nxt;
        acc_max   <= max_nxt;
        acc_min   <= min_nxt;
        seen      <= seen_nxt;
      end
    end
  end

  assign Busy = Enable & ~Reset;

`ifdef MON_PERIOD_EN
  logic [31:0] per_cnt;
  logic        armed;

  // armed marks that a first crossing has been seen since reset or Enable rise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      per_cnt    <= '0;
      armed      <= 1'b0;
      Period_Cnt <= '0;
    end else if (!Enable) begin
      per_cnt <= '0;
      armed   <= 1'b0;
    end else if (rise) begin
      per_cnt <= 32'd1;
      armed   <= 1'b1;
      if (armed) Period_Cnt <= per_cnt;
    end else if (per_cnt != 32'hFFFF_FFFF) begin
      per_cnt <= per_cnt + 32'd1;
    end
  end
`else
  assign Period_Cnt = '0;
`endif

endmodule

// File: tb/tb_dds_sample_monitor.sv
// tb/tb_dds_sample_monitor.sv - directed self-checking bench for dds_sample_monitor
module tb_dds_sample_monitor;

  localparam int DATA_W = 14;
  localparam int GATE   = 10000;

  localparam int M_SQUARE  = 0;
  localparam int M_CHATTER = 1;
  localparam int M_INVALID = 2;

  logic              Clk = 1'b0;
  logic              Reset, Enable, Sample_Valid;
  logic [DATA_W-1:0] Sample;
  logic [31:0]       Freq_Count, Period_Cnt;
  logic [DATA_W-1:0] Max_Val, Min_Val, Vpp;
  logic              Meas_Valid, Busy;

  int compared = 0;
  int mismatched = 0;
  int mv_count;
  int last_pulse;
  int nonzero_in_reset;

  dds_sample_monitor #(.DATA_W(DATA_W), .GATE_CYCLES(GATE), .HYST(256)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Sample(Sample), .Sample_Valid(Sample_Valid),
    .Freq_Count(Freq_Count), .Max_Val(Max_Val), .Min_Val(Min_Val), .Vpp(Vpp),
    .Period_Cnt(Period_Cnt), .Meas_Valid(Meas_Valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives n cycles of a pattern; i is the cycle index within this run.
  task automatic run_cycles(input int n, input int mode);
    mv_count   = 0;
    last_pulse = -1;
    for (int i = 0; i < n; i++) begin
      Sample_Valid = (mode != M_INVALID);
      case (mode)
        M_SQUARE:  Sample = ((i / 100) % 2 == 1) ? 14'd16383 : 14'd0;
        M_CHATTER: Sample = (i % 2 == 0) ? 14'd8392 : 14'd7992;
        default:   Sample = 14'(($urandom));
      endcase
      tick();
      if (Meas_Valid === 1'b1) begin
        mv_count++;
        last_pulse = i;
      end
    end
  endtask

  initial begin
    Reset        = 1'b1;
    Enable       = 1'b1;
    Sample_Valid = 1'b1;
    Sample       = '0;
    nonzero_in_reset = 0;

    for (int i = 0; i < 10; i++) begin
      Sample = 14'($urandom);
      tick();
      if ({Freq_Count, Max_Val, Min_Val, Vpp, Period_Cnt, Meas_Valid, Busy} !== '0)
        nonzero_in_reset++;
    end
    check("reset_outputs_zero_cycles", 32'(nonzero_in_reset), 32'd0);
    check("reset_freq", Freq_Count, 32'd0);
    check("reset_vpp", 32'(Vpp), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);

    Reset = 1'b0;
    run_cycles(GATE, M_SQUARE);
    check("sq_pulses", 32'(mv_count), 32'd1);
    check("sq_pulse_pos", 32'(last_pulse), 32'(GATE - 1));
    check("sq_freq", Freq_Count, 32'd50);
    check("sq_max", 32'(Max_Val), 32'd16383);
    check("sq_min", 32'(Min_Val), 32'd0);
    check("sq_vpp", 32'(Vpp), 32'd16383);
    check("sq_busy", 32'(Busy), 32'd1);
`ifdef MON_PERIOD_EN
    check("sq_period", Period_Cnt, 32'd200);
`else
    check("sq_period", Period_Cnt, 32'd0);
`endif

    run_cycles(GATE, M_CHATTER);
    check("ch_pulses", 32'(mv_count), 32'd1);
    check("ch_freq", Freq_Count, 32'd0);
    check("ch_max", 32'(Max_Val), 32'd8392);
    check("ch_min", 32'(Min_Val), 32'd7992);
    check("ch_vpp", 32'(Vpp), 32'd400);

    run_cycles(GATE, M_INVALID);
    check("inv_pulses", 32'(mv_count), 32'd1);
    check("inv_pulse_pos", 32'(last_pulse), 32'(GATE - 1));
    check("inv_freq", Freq_Count, 32'd0);
    check("inv_max", 32'(Max_Val), 32'd0);
    check("inv_min", 32'(Min_Val), 32'd0);
    check("inv_vpp", 32'(Vpp), 32'd0);

    run_cycles(5000, M_SQUARE);
    check("en_first_half_pulses", 32'(mv_count), 32'd0);
    Enable = 1'b0;
    run_cycles(10, M_INVALID);
    check("en_off_pulses", 32'(mv_count), 32'd0);
    check("en_off_busy", 32'(Busy), 32'd0);
    check("en_off_hold_max", 32'(Max_Val), 32'd0);
    Enable = 1'b1;
    run_cycles(GATE, M_SQUARE);
    check("en_back_pulses", 32'(mv_count), 32'd1);
    check("en_back_pulse_pos", 32'(last_pulse), 32'(GATE - 1));
    check("en_back_freq", Freq_Count, 32'd50);
    check("en_back_vpp", 32'(Vpp), 32'd16383);
`ifdef MON_PERIOD_EN
    check("en_back_period", Period_Cnt, 32'd200);
`else
    check("en_back_period", Period_Cnt, 32'd0);
`endif

    run_cycles(3000, M_SQUARE);
    Reset = 1'b1;
    tick();
    check("midreset_freq", Freq_Count, 32'd0);
    check("midreset_max", 32'(Max_Val), 32'd0);
    check("midreset_vpp", 32'(Vpp), 32'd0);
    check("midreset_period", Period_Cnt, 32'd0);
    check("midreset_meas_valid", 32'(Meas_Valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
